fft8_bitrev_buffer: RTL



---
 rtl/fft8_bitrev_buffer_if.sv | 30 +++
 rtl/fft8_bitrev_buffer.sv | 113 +++++++++++
 2 files changed

// File: rtl/fft8_bitrev_buffer_if.sv
// Stream bundle for the 8-point FFT input reordering stage.
// The master side produces input samples and consumes reordered samples;
// the slave side is the reorder buffer itself.
interface fft8_bitrev_buffer_if #(
    parameter int DATA_WIDTH = 16
);
    // Natural-order input stream
    logic                         in_valid;
    logic                         in_ready;
    logic signed [DATA_WIDTH-1:0] in_real;
    logic signed [DATA_WIDTH-1:0] in_imag;

    // Bit-reversed output stream towards the first butterfly stage
    logic                         out_valid;
    logic                         out_ready;
    logic signed [DATA_WIDTH-1:0] out_real;
    logic signed [DATA_WIDTH-1:0] out_imag;
    logic [2:0]                   out_index;
    logic                         out_last;

    modport master (
        output in_valid, in_real, in_imag, out_ready,
        input  in_ready, out_valid, out_real, out_imag, out_index, out_last
    );

    modport slave (
        input  in_valid, in_real, in_imag, out_ready,
        output in_ready, out_valid, out_real, out_imag, out_index, out_last
    );
endinterface

// File: rtl/fft8_bitrev_buffer.sv
// Ping-pong frame buffer that turns a natural-order complex sample stream
// into 8-sample frames replayed in bit-reversed order (0,4,2,6,1,5,3,7).
// One bank fills while the other drains, giving one sample per clock.
// Storage is kept in resettable registers so that a reset clears the
// data outputs immediately along with the control state.
module fft8_bitrev_buffer #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    fft8_bitrev_buffer_if.slave  bus
);
    localparam int EW = 2 * DATA_WIDTH;

    // Write-side pointers: bank being filled and slot within it
    logic       r_wbank;
    logic [2:0] r_wcnt;
    // Read-side pointers: bank being drained and output slot
    logic       r_rbank;
    logic [2:0] r_rcnt;
    // One flag per bank: frame complete and not yet fully read
    logic [1:0] r_full;

    // Entry view of storage, addressed as {bank, slot}
    logic [EW-1:0] w_mem [0:15];

    logic          w_wr_fire;
    logic          w_rd_fire;
    logic          w_wr_done;
    logic          w_rd_done;
    logic [2:0]    w_rd_slot;
    logic [EW-1:0] w_rd_word;

    // Handshakes depend only on registered flags, so there is no path from
    // out_ready to in_ready nor from in_valid to out_valid.
    assign bus.in_ready  = ~r_full[r_wbank];
    assign bus.out_valid = r_full[r_rbank];

    assign w_wr_fire = bus.in_valid & ~r_full[r_wbank];
    assign w_rd_fire = r_full[r_rbank] & bus.out_ready;
    assign w_wr_done = w_wr_fire & (r_wcnt == 3'd7);
    assign w_rd_done = w_rd_fire & (r_rcnt == 3'd7);

    // Output slot k reads stored sample bitrev(k)
    assign w_rd_slot = {r_rcnt[0], r_rcnt[1], r_rcnt[2]};
    assign w_rd_word = w_mem[{r_rbank, w_rd_slot}];

    assign bus.out_real  = w_rd_word[EW-1:DATA_WIDTH];
    assign bus.out_imag  = w_rd_word[DATA_WIDTH-1:0];
    assign bus.out_index = r_rcnt;
    assign bus.out_last  = r_full[r_rbank] & (r_rcnt == 3'd7);

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_entry
            logic [EW-1:0] r_word;

            // Capture the incoming sample when this entry is the write target
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_word <= '0;
                end else if (w_wr_fire && ({r_wbank, r_wcnt} == 4'(gi))) begin
                    r_word <= {bus.in_real, bus.in_imag};
                end
            end

            assign w_mem[gi] = r_word;
        end
    endgenerate

    // Advance the write pointer on each accepted sample; switch bank after slot 7
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wbank <= 1'b0;
            r_wcnt  <= 3'd0;
        end else if (w_wr_fire) begin
            r_wcnt <= r_wcnt + 3'd1;
            if (r_wcnt == 3'd7) begin
                r_wbank <= ~r_wbank;
            end
        end
    end

    // Advance the read pointer on each accepted output; switch bank after slot 7
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rbank <= 1'b0;
            r_rcnt  <= 3'd0;
        end else if (w_rd_fire) begin
            r_rcnt <= r_rcnt + 3'd1;
            if (r_rcnt == 3'd7) begin
                r_rbank <= ~r_rbank;
            end
        end
    end

    // Set a bank's flag when its frame completes, clear it when fully read.
    // Writer and reader never target the same bank in one cycle, so the two
    // updates are independent.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_full <= 2'b00;
        end else begin
            for (int b = 0; b < 2; b++) begin
                if (w_wr_done && (r_wbank == 1'(b))) begin
                    r_full[b] <= 1'b1;
                end else if (w_rd_done && (r_rbank == 1'(b))) begin
                    r_full[b] <= 1'b0;
                end
            end
        end
    end
endmodule
